// File: rtl/iter_alu_if.sv
// rtl/iter_alu_if.sv - operand/result handshake bundle for the iterative ALU
interface iter_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       op_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             overflow_o;
  logic             illegal_o;

  modport master (
    output in_valid_i, src1_i, src2_i, op_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o, overflow_o, illegal_o
  );

  modport slave (
    input  in_valid_i, src1_i, src2_i, op_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o, overflow_o, illegal_o
  );
endinterface

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - handshaked EX-stage ALU with iterative unsigned mul/divu/remu
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  iter_alu_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               ovf_q;
  logic               ill_q;

  logic               accept;
  logic               iter_op;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_ovf;
  logic               sc_ill;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] p_next;
  logic [WIDTH-1:0]   it_result;
  logic               it_ovf;

  assign bus.in_ready_o  = (state == IDLE) | ((state == DONE) & bus.out_ready_i);
  assign accept          = bus.in_valid_i & bus.in_ready_o;
  assign iter_op         = (bus.op_i == OP_MUL) | (bus.op_i == OP_DIVU) | (bus.op_i == OP_REMU);
  assign bus.out_valid_o = (state == DONE);
  assign bus.result_o    = result_q;
  assign bus.zero_o      = zero_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.illegal_o   = ill_q;

  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_ill    = 1'b0;
    case (bus.op_i)
      OP_ADD: begin
        sc_result = bus.src1_i + bus.src2_i;
        sc_ovf    = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &
                    (sc_result[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = bus.src1_i - bus.src2_i;
        sc_ovf    = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &
                    (sc_result[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      OP_AND:  sc_result = bus.src1_i & bus.src2_i;
      OP_OR:   sc_result = bus.src1_i | bus.src2_i;
      OP_NOR:  sc_result = ~(bus.src1_i | bus.src2_i);
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      default: sc_ill = 1'b1;
    endcase
  end

  // p_q is {acc, multiplier} for mul and {remainder, quotient} for division
  always_comb begin
    mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    div_shift = p_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, b_q};
    if (op_q == OP_MUL) begin
      p_next = {mul_sum, p_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      p_next = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    end else begin
      p_next = {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
    end
    case (op_q)
      OP_MUL: begin
        it_result = p_next[WIDTH-1:0];
        it_ovf    = |p_next[2*WIDTH-1:WIDTH];
      end
      OP_DIVU: begin
        it_result = p_next[WIDTH-1:0];
        it_ovf    = (b_q == '0);
      end
      default: begin
        it_result = p_next[2*WIDTH-1:WIDTH];
        it_ovf    = (b_q == '0);
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          p_q <= p_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            result_q <= it_result;
            zero_q   <= (it_result == '0);
            ovf_q    <= it_ovf;
            ill_q    <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            op_q <= bus.op_i;
            a_q  <= bus.src1_i;
            b_q  <= bus.src2_i;
            if (iter_op) begin
              state <= BUSY;
              cnt   <= CNT_W'(WIDTH);
              p_q   <= {{WIDTH{1'b0}}, (bus.op_i == OP_MUL) ? bus.src2_i : bus.src1_i};
            end else begin
              state    <= DONE;
              result_q <= sc_result;
              zero_q   <= (sc_result == '0);
              ovf_q    <= sc_ovf;
              ill_q    <= sc_ill;
            end
          end else if ((state == DONE) && bus.out_ready_i) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - vector table, corner sequences and random checks for iter_alu
module tb_iter_alu;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  iter_alu_if #(.WIDTH(W)) bus ();
  iter_alu #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference from arithmetic definitions, not from the datapath structure
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ovf, output logic ill,
                                output int lat);
    longint      s;
    logic [63:0] p;
    r = '0; ovf = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      4'b0010: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r = a + b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = a - b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[31:0];
        ovf = (p[63:32] != 32'd0);
        lat = W + 1;
      end
      4'b1001: begin
        r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        ovf = (b == 0);
        lat = W + 1;
      end
      4'b1010: begin
        r = (b == 0) ? a : a % b;
        ovf = (b == 0);
        lat = W + 1;
      end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic ovf,
                        input logic zero, input logic ill, input int lat_exp);
    int   lat;
    logic ready_seen;
    @(negedge clk);
    bus.in_valid_i  = 1'b1;
    bus.src1_i      = a;
    bus.src2_i      = b;
    bus.op_i        = op;
    bus.out_ready_i = 1'b0;
    #1 check({name, " in_ready"}, 64'(bus.in_ready_o), 64'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    bus.src1_i     = $urandom;
    bus.src2_i     = $urandom;
    bus.op_i       = 4'($urandom);
    lat = 1;
    ready_seen = 1'b0;
    while (!bus.out_valid_o && lat < 200) begin
      if (bus.in_ready_o) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.in_ready_o) ready_seen = 1'b1;
    check({name, " latency"}, 64'(lat), 64'(lat_exp));
    check({name, " ready_low"}, 64'(ready_seen), 64'd0);
    check({name, " result"}, 64'(bus.result_o), 64'(res));
    check({name, " flags"}, {61'd0, bus.overflow_o, bus.zero_o, bus.illegal_o},
          {61'd0, ovf, zero, ill});
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    check({name, " drained"}, 64'(bus.out_valid_o), 64'd0);
  endtask

  initial begin
    logic [3:0]  ops[10];
    logic [3:0]  op;
    logic [31:0] a, b, r;
    logic        ovf, ill, ok, pulsed;
    int          lat;

    vecs[0]  = '{"add_ovf",   4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{"sub_ovf",   4'b0110, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{"sub_zero",  4'b0110, 32'd5,         32'd5,         32'h0,         1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{"mul_hi",    4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0,         1'b1, 1'b1, 1'b0, 33};
    vecs[4]  = '{"divu",      4'b1001, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 1'b0, 33};
    vecs[5]  = '{"remu",      4'b1010, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 1'b0, 33};
    vecs[6]  = '{"divu_z",    4'b1001, 32'd9,         32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 33};
    vecs[7]  = '{"remu_z",    4'b1010, 32'd9,         32'd0,         32'd9,         1'b1, 1'b0, 1'b0, 33};
    vecs[8]  = '{"and",       4'b0000, 32'hF0,        32'h3C,        32'h30,        1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{"or",        4'b0001, 32'h0F,        32'hF0,        32'hFF,        1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{"nor",       4'b1100, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{"slt_t",     4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{"slt_f",     4'b0111, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 1'b0, 1};
    vecs[13] = '{"illegal",   4'b0011, 32'd5,         32'd6,         32'h0,         1'b0, 1'b1, 1'b1, 1};
    vecs[14] = '{"mul_max",   4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b1, 1'b0, 1'b0, 33};
    vecs[15] = '{"mul_small", 4'b1000, 32'd3,         32'd5,         32'd15,        1'b0, 1'b0, 1'b0, 33};
    vecs[16] = '{"add_neg",   4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1, 1'b1, 1'b0, 1};
    vecs[17] = '{"sub_mix",   4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1};

    ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1111};

    bus.in_valid_i  = 1'b0;
    bus.src1_i      = '0;
    bus.src2_i      = '0;
    bus.op_i        = '0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 64'(bus.out_valid_o), 64'd0);
    check("reset result", 64'(bus.result_o), 64'd0);
    check("reset flags", {61'd0, bus.overflow_o, bus.zero_o, bus.illegal_o}, 64'b010);
    check("reset in_ready", 64'(bus.in_ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].ovf, vecs[i].zero, vecs[i].ill, vecs[i].lat);

    // Stalled consumer, then back-to-back accept in the release cycle
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.op_i = 4'b0000; bus.src1_i = 32'hF0; bus.src2_i = 32'h3C;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!bus.out_valid_o || bus.result_o != 32'h30 || bus.in_ready_o) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("hold stable", 64'(ok), 64'd1);
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    bus.in_valid_i = 1'b1; bus.op_i = 4'b0001; bus.src1_i = 32'h0F; bus.src2_i = 32'hF0;
    #1 check("b2b in_ready", 64'(bus.in_ready_o), 64'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    check("b2b valid", 64'(bus.out_valid_o), 64'd1);
    check("b2b result", 64'(bus.result_o), 64'hFF);
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    check("b2b idle", 64'(bus.out_valid_o), 64'd0);

    // Asynchronous reset in the middle of a division
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.op_i = 4'b1001; bus.src1_i = 32'd1000; bus.src2_i = 32'd3;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", 64'(bus.in_ready_o), 64'd1);
    check("midrst result", 64'(bus.result_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulsed = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid_o) pulsed = 1'b1;
    end
    check("midrst no_pulse", 64'(pulsed), 64'd0);
    run_op("post_rst_add", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0, 1);

    for (int n = 0; n < 30; n++) begin
      op = ops[$urandom_range(0, 9)];
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      b  = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 17));
      model(op, a, b, r, ovf, ill, lat);
      run_op($sformatf("rand%0d_op%b", n, op), op, a, b, r, ovf, (r == 32'd0), ill, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
